// File: rtl/demux_pkg.sv
// Shared constants and types for the buffered 1-to-4 word demultiplexer.
package demux_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned STAT_W    = 8;

  typedef logic [1:0] ch_sel_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/demux4_16b_buf_chan_fifo.sv
// Single-channel DEPTH-entry FIFO; head word is forced to zero while empty.
module chan_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux4_16b_buf.sv
// Buffered 1-to-4 demux: select decode, in_ready mux and per-channel FIFOs.
// Optional saturating accepted-word counters are built when DEMUX_STATS_EN is defined.
module demux4_16b_buf
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ack,
  output logic [31:0]      stat_count
);

  logic [NUM_CH-1:0]              full;
  logic [NUM_CH-1:0]              empty;
  logic [NUM_CH-1:0]              push;
  logic [NUM_CH-1:0]              pop;
  logic [WIDTH-1:0]               rdata [NUM_CH];
  logic [$clog2(DEPTH+1)-1:0]     count [NUM_CH];

  assign in_ready = !full[in_sel];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign push[k]      = in_valid && in_ready && (ch_sel_t'(in_sel) == ch_sel_t'(k));
    assign pop[k]       = out_ack[k] && !empty[k];
    assign out_valid[k] = (count[k] != '0);

    chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push[k]),
      .wdata   (in_data),
      .pop     (pop[k]),
      .rdata   (rdata[k]),
      .count   (count[k]),
      .full    (full[k]),
      .empty   (empty[k])
    );
  end

  assign out1 = rdata[0];
  assign out2 = rdata[1];
  assign out3 = rdata[2];
  assign out4 = rdata[3];

`ifdef DEMUX_STATS_EN
  logic [STAT_W-1:0] stat [NUM_CH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) stat[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++)
        if (push[i]) stat[i] <= sat_inc(stat[i]);
    end
  end

  assign stat_count = {stat[3], stat[2], stat[1], stat[0]};
`else
  assign stat_count = '0;
`endif

endmodule

// File: tb/tb_demux4_16b_buf.sv
// Self-checking bench for demux4_16b_buf against a queue-based channel model.
module tb_demux4_16b_buf;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out1, out2, out3, out4;
  logic [3:0]  out_valid;
  logic [3:0]  out_ack;
  logic [31:0] stat_count;
  logic [15:0] outs [4];

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q [4][$];
  int unsigned stat_m [4];

  demux4_16b_buf #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out4       (out4),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .stat_count (stat_count)
  );

  always #5 clock = ~clock;

  always_comb begin
    outs[0] = out1;
    outs[1] = out2;
    outs[2] = out3;
    outs[3] = out4;
  end

  function automatic logic [15:0] exp_out(int k);
    return (q[k].size() == 0) ? 16'h0000 : q[k][0];
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (q[k].size() != 0);
    return v;
  endfunction

  function automatic logic [31:0] exp_stat();
`ifdef DEMUX_STATS_EN
    logic [31:0] s;
    for (int k = 0; k < 4; k++) s[8*k +: 8] = stat_m[k][7:0];
    return s;
`else
    return 32'h0;
`endif
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      stat_m[k] = 0;
    end
  endfunction

  task automatic drive(input logic [15:0] d, input logic [1:0] s, input logic v, input logic [3:0] a);
    @(negedge clock);
    in_data  = d;
    in_sel   = s;
    in_valid = v;
    out_ack  = a;
    #1;
  endtask

  // Model: pops act on pre-edge contents, then the accepted word is appended.
  task automatic tick();
    logic acc;
    @(posedge clock);
    acc = in_valid && (q[in_sel].size() < DEPTH);
    for (int k = 0; k < 4; k++)
      if (out_ack[k] && q[k].size() != 0) void'(q[k].pop_front());
    if (acc) begin
      q[in_sel].push_back(in_data);
      if (stat_m[in_sel] < 255) stat_m[in_sel]++;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n  = 1'b0;
    in_data  = '0;
    in_sel   = '0;
    in_valid = 1'b0;
    out_ack  = '0;
    model_clear();
    #2;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++;
    if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
    n_checks++;
    if ({out1, out2, out3, out4} !== 64'h0) begin n_fail++; $display("FAIL reset_outs got=%h exp=0", {out1, out2, out3, out4}); end
    n_checks++;
    if (stat_count !== 32'h0) begin n_fail++; $display("FAIL reset_stat got=%h exp=0", stat_count); end
  endtask

  task automatic test_routing();
    logic [15:0] w;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      w = 16'h0061 + 16'(k);
      drive(w, 2'(k), 1'b1, 4'b0000);
      tick();
      n_checks++;
      if (outs[k] !== w || out_valid[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL routing_ch%0d got=%h/%b exp=%h/1", k, outs[k], out_valid[k], w);
      end
    end
    n_checks++;
    if (out_valid !== 4'b1111 || {out1, out2, out3, out4} !== 64'h0061_0062_0063_0064) begin
      n_fail++;
      $display("FAIL routing_all got=%b %h exp=1111 0061006200630064", out_valid, {out1, out2, out3, out4});
    end
  endtask

  task automatic test_full_backpressure();
    do_reset();
    drive(16'h0001, 2'd2, 1'b1, 4'b0000); tick();
    drive(16'h0002, 2'd2, 1'b1, 4'b0000); tick();
    drive(16'h0003, 2'd2, 1'b1, 4'b0000);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out3 !== 16'h0001) begin
      n_fail++; $display("FAIL full_hold got=%b/%h exp=0/0001", in_ready, out3);
    end
    drive(16'h0003, 2'd2, 1'b1, 4'b0100); tick();
    n_checks++;
    if (in_ready !== 1'b1 || out3 !== 16'h0002) begin
      n_fail++; $display("FAIL full_release got=%b/%h exp=1/0002", in_ready, out3);
    end
    drive(16'h0003, 2'd2, 1'b1, 4'b0100); tick();
    n_checks++;
    if (out3 !== 16'h0003 || out_valid[2] !== 1'b1) begin
      n_fail++; $display("FAIL full_order3 got=%h/%b exp=0003/1", out3, out_valid[2]);
    end
    drive(16'h0000, 2'd2, 1'b0, 4'b0100); tick();
    n_checks++;
    if (out_valid[2] !== 1'b0 || out3 !== 16'h0000) begin
      n_fail++; $display("FAIL full_drained got=%b/%h exp=0/0000", out_valid[2], out3);
    end
  endtask

  task automatic test_push_pop_same();
    do_reset();
    drive(16'hAAAA, 2'd0, 1'b1, 4'b0000); tick();
    drive(16'hBBBB, 2'd0, 1'b1, 4'b0001);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL same_in_ready got=%b exp=1", in_ready); end
    tick();
    n_checks++;
    if (out_valid[0] !== 1'b1 || out1 !== 16'hBBBB) begin
      n_fail++; $display("FAIL same_head got=%b/%h exp=1/bbbb", out_valid[0], out1);
    end
    drive(16'h0000, 2'd0, 1'b0, 4'b0001); tick();
    n_checks++;
    if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL same_count1 got=%b exp=0", out_valid[0]); end
  endtask

  task automatic test_ack_empty_wrap();
    logic [15:0] w;
    do_reset();
    drive(16'h0000, 2'd0, 1'b0, 4'b1111); tick();
    n_checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1 || {out1, out2, out3, out4} !== 64'h0) begin
      n_fail++; $display("FAIL ack_empty got=%b/%b exp=0000/1", out_valid, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      w = 16'($urandom);
      drive(w, 2'd1, 1'b1, 4'b0000); tick();
      n_checks++;
      if (out2 !== w || out_valid !== 4'b0010) begin
        n_fail++; $display("FAIL wrap_push%0d got=%h/%b exp=%h/0010", i, out2, out_valid, w);
      end
      drive(16'h0000, 2'd1, 1'b0, 4'b0010); tick();
      n_checks++;
      if (out_valid !== 4'b0000 || out2 !== 16'h0000) begin
        n_fail++; $display("FAIL wrap_pop%0d got=%b/%h exp=0000/0000", i, out_valid, out2);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < DEPTH; j++) begin
        drive(16'($urandom), 2'(k), 1'b1, 4'b0000);
        tick();
      end
    n_checks++;
    if (out_valid !== 4'b1111) begin n_fail++; $display("FAIL async_fill got=%b exp=1111", out_valid); end
    @(negedge clock);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1 || {out1, out2, out3, out4} !== 64'h0) begin
      n_fail++; $display("FAIL async_reset got=%b/%b/%h exp=0000/1/0", out_valid, in_ready, {out1, out2, out3, out4});
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_random();
    logic [3:0] ev;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive(16'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 4'($urandom));
      n_checks++;
      if (in_ready !== (q[in_sel].size() != DEPTH)) begin
        n_fail++; $display("FAIL rand_in_ready c=%0d got=%b exp=%b", c, in_ready, (q[in_sel].size() != DEPTH));
      end
      tick();
      ev = exp_valid();
      n_checks++;
      if (out_valid !== ev) begin n_fail++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, out_valid, ev); end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (outs[k] !== exp_out(k)) begin
          n_fail++; $display("FAIL rand_out%0d c=%0d got=%h exp=%h", k + 1, c, outs[k], exp_out(k));
        end
      end
      n_checks++;
      if (stat_count !== exp_stat()) begin
        n_fail++; $display("FAIL rand_stat c=%0d got=%h exp=%h", c, stat_count, exp_stat());
      end
    end
  endtask

  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(16'(i), 2'd3, 1'b1, 4'b1000);
      tick();
    end
    n_checks++;
    if (stat_count !== exp_stat()) begin n_fail++; $display("FAIL stats_model got=%h exp=%h", stat_count, exp_stat()); end
`ifdef DEMUX_STATS_EN
    n_checks++;
    if (stat_count !== 32'hFF00_0000) begin n_fail++; $display("FAIL stats_sat got=%h exp=ff000000", stat_count); end
`else
    n_checks++;
    if (stat_count !== 32'h0) begin n_fail++; $display("FAIL stats_off got=%h exp=0", stat_count); end
`endif
    n_checks++;
    if (out4 !== 16'd299 || out_valid !== 4'b1000) begin
      n_fail++; $display("FAIL stats_last got=%h/%b exp=012b/1000", out4, out_valid);
    end
  endtask

  initial begin
    reset_n  = 1'b1;
    in_data  = '0;
    in_sel   = '0;
    in_valid = 1'b0;
    out_ack  = '0;
    model_clear();
    test_reset();
    test_routing();
    test_full_backpressure();
    test_push_pop_same();
    test_ack_empty_wrap();
    test_async_reset();
    test_random();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
